surfturf_cmd_scheduler: RTL
===========================

// Module: surfturf_cmd_scheduler
// PURPOSE
//  Sysclk-domain scheduler that shares the single TURFIO->SURF command slot between three AXI4-S sources:
//   - runcmd (RACKBUS_RUNCMD_BITS)
//   - trig (RACKBUS_TRIG_BITS)
//   - fw update bytes (8 b, plus 2-bit mark)
//  Sits between the wishbone register core's sysclk-side streams and the command serializer.
//  Emits one tagged command word per frame of FRAME_LEN sysclks, in fixed priority with a fw anti-starvation guard.
// PARAMETERS
//  FRAME_LEN      4   sysclks per command slot; legal range 2..16
//  FW_STARVE_MAX  8   consecutive fw-denied frames before fw is forced ahead of trig; legal range 1..255
//  RUNCMD_BITS    `RACKBUS_RUNCMD_BITS  runcmd payload width (2)
//  TRIG_BITS      `RACKBUS_TRIG_BITS    trig payload width (15)
// PORTS
//  sysclk_i        in   1   clock
//  rst_i           in   1   asynchronous reset, active-high
//  en_i            in   1   scheduler enable; low = IDLE words only, no tready
//  runcmd_tdata    in   RUNCMD_BITS   runcmd payload
//  runcmd_tvalid   in   1   runcmd valid
//  runcmd_tready   out  1   runcmd accept
//  trig_tdata      in   TRIG_BITS     trigger payload
//  trig_tvalid     in   1   trig valid
//  trig_tready     out  1   trig accept
//  fw_tdata        in   8   fw update byte
//  fw_tvalid       in   1   fw valid
//  fw_tready       out  1   fw accept
//  fw_mark_i       in   2   mark bits attached to the fw byte being accepted
//  fw_marked_o     out  1   1-cycle pulse: fw byte with nonzero mark issued
//  cmd_o           out  20  command word: [19:18] type, [17:0] payload
//  cmd_valid_o     out  1   1-cycle pulse per frame, every frame
//  frame_o         out  1   1-cycle pulse on last cycle of each frame (decision cycle)
// BEHAVIOUR
//  Reset values: all outputs 0; frame counter 0; starve counter 0.
//  Frame counter counts 0..FRAME_LEN-1 and wraps.
//   - Decision cycle D: counter == FRAME_LEN-1; frame_o = 1 in D.
//   - The counter runs regardless of en_i.
//  Grant in D; combinational tready, only when en_i=1.
//   - Priority 1: runcmd_tvalid -> runcmd_tready=1.
//   - Priority 2: trig_tvalid and !(fw_tvalid && starve==FW_STARVE_MAX) -> trig_tready=1.
//   - Priority 3: fw_tvalid -> fw_tready=1.
//   - Otherwise no tready is asserted and the frame is IDLE.
//   - At most one tready is asserted per frame.
//   - tready is never asserted outside D, and is never asserted without the matching tvalid.
//  Issue: cycle D+1 registers cmd_o and pulses cmd_valid_o.
//   - type 2'b00 IDLE: payload 0.
//   - type 2'b01 RUNCMD: payload = {0, runcmd_tdata}.
//   - type 2'b10 TRIG: payload = {0, trig_tdata}.
//   - type 2'b11 FW: payload = {0, fw_mark_i, fw_tdata}, where payload[9:8] = mark.
//   - cmd_o holds its value until the next issue; fw_marked_o pulses in D+1 iff FW issued with mark != 0.
//   - Latency from accept to cmd_valid_o: 1 cycle.
//  Starve counter (8 b):
//   - Increments in D when fw_tvalid && !fw_tready && trig_tready; saturates at FW_STARVE_MAX.
//   - Clears in D when fw_tready.
//   - Holds in any frame where runcmd wins, because runcmd never counts against fw.
//   - Holds when fw_tvalid=0 or en_i=0.
//  Boundaries:
//   - tvalid dropping before D is legal; that source is simply not granted.
//   - All three sources valid: runcmd wins. While runcmd persists, trig and fw wait indefinitely; this is by design.
//   - Starve saturated but fw_tvalid=0: trig is granted normally and the counter holds.
//   - en_i falling mid-frame: that frame's D issues IDLE. en_i rising mid-frame: it takes effect at the next D.
//   - rst_i mid-frame: the pending grant is dropped; no cmd_valid_o follows until the first D after release.
// STRUCTURE
//  Type codes (CMD_IDLE/RUNCMD/TRIG/FW) and the cmd_o field layout go in rackbus.vh as `RACKBUS_CMD_* defines.
//  Flat module; no sub-module is required. Frame counter, grant logic, starve counter and output register are all in one file.
// TESTING
//  1. Only runcmd_tvalid, data 2'b10, en_i=1 -> one runcmd_tready at D; cmd_o=20'h40002 at D+1; then IDLE words 20'h00000 every FRAME_LEN cycles.
//  2. runcmd, trig=15'h1234 and fw=8'hA5 all held valid -> order RUNCMD, TRIG, FW; one tready per frame; cmd_o 20'h4xxxx, then 20'h81234, then 20'hC00A5.
//  3. trig and fw held valid for 20 frames -> 8 TRIG frames, then FW in frame 9, starve counter back to 0, then trig again.
//  4. fw 8'h3C with fw_mark_i=2'b01 -> cmd_o=20'hC013C and fw_marked_o pulses once at D+1; with mark 2'b00 there is no pulse.
//  5. en_i=0 with all sources valid for 5 frames -> no tready asserted; 5 IDLE cmd_valid_o pulses.
//  6. rst_i asserted one cycle before D with trig valid -> no tready and no cmd_valid_o; after release, the first issue is exactly FRAME_LEN cycles later.

Source files
------------

// File: rtl/surfturf_cmd_scheduler_pkg.sv
// Shared types and field layout for the TURFIO->SURF command slot scheduler.
package surfturf_cmd_scheduler_pkg;

  localparam int unsigned CMD_W     = 20;
  localparam int unsigned PAYLOAD_W = 18;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned STARVE_W  = 8;
  localparam int unsigned FW_BITS   = 8;
  localparam int unsigned MARK_W    = 2;

  typedef enum logic [1:0] {
    CMD_IDLE   = 2'b00,
    CMD_RUNCMD = 2'b01,
    CMD_TRIG   = 2'b10,
    CMD_FW     = 2'b11
  } cmd_type_e;

  typedef struct packed {
    cmd_type_e              cmd_type;
    logic [PAYLOAD_W-1:0]   payload;
  } cmd_word_t;

  function automatic cmd_word_t make_cmd(input cmd_type_e t, input logic [PAYLOAD_W-1:0] p);
    cmd_word_t w;
    w.cmd_type = t;
    w.payload  = p;
    return w;
  endfunction

endpackage

// File: rtl/surfturf_cmd_scheduler.sv
// Shares the single command slot between runcmd, trig and fw streams: one tagged
// word per frame, fixed priority with an anti-starvation guard that lifts fw above trig.
module surfturf_cmd_scheduler
  import surfturf_cmd_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = 4,
  parameter int unsigned FW_STARVE_MAX = 8,
  parameter int unsigned RUNCMD_BITS   = 2,
  parameter int unsigned TRIG_BITS     = 15
) (
  input  logic                   sysclk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
  input  logic                   runcmd_tvalid,
  output logic                   runcmd_tready,
  input  logic [TRIG_BITS-1:0]   trig_tdata,
  input  logic                   trig_tvalid,
  output logic                   trig_tready,
  input  logic [FW_BITS-1:0]     fw_tdata,
  input  logic                   fw_tvalid,
  output logic                   fw_tready,
  input  logic [MARK_W-1:0]      fw_mark_i,
  output logic                   fw_marked_o,
  output logic [CMD_W-1:0]       cmd_o,
  output logic                   cmd_valid_o,
  output logic                   frame_o
);

  localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(FRAME_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FW_STARVE_MAX);

  logic [CNT_W-1:0]    r_cnt;
  logic [STARVE_W-1:0] r_starve;
  logic [CMD_W-1:0]    r_cmd;
  logic                r_cmd_valid;
  logic                r_fw_marked;

  logic      w_dec;
  logic      w_starved;
  logic      w_gnt_run;
  logic      w_gnt_trig;
  logic      w_gnt_fw;
  cmd_word_t w_cmd;

  assign w_dec     = (r_cnt == LAST_CNT);
  assign w_starved = (r_starve == STARVE_MAX);

  // Decision-cycle grant: at most one source wins, and only while enabled.
  always_comb begin
    w_gnt_run  = 1'b0;
    w_gnt_trig = 1'b0;
    w_gnt_fw   = 1'b0;
    w_cmd      = make_cmd(CMD_IDLE, '0);
    if (en_i && w_dec) begin
      if (runcmd_tvalid) begin
        w_gnt_run = 1'b1;
        w_cmd     = make_cmd(CMD_RUNCMD, PAYLOAD_W'(runcmd_tdata));
      end else if (trig_tvalid && !(fw_tvalid && w_starved)) begin
        w_gnt_trig = 1'b1;
        w_cmd      = make_cmd(CMD_TRIG, PAYLOAD_W'(trig_tdata));
      end else if (fw_tvalid) begin
        w_gnt_fw = 1'b1;
        w_cmd    = make_cmd(CMD_FW, PAYLOAD_W'({fw_mark_i, fw_tdata}));
      end
    end
  end

  // Frame counter, starve tracking and the issued-word register.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_starve    <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_fw_marked <= 1'b0;
    end else begin
      r_cnt       <= w_dec ? '0 : r_cnt + CNT_W'(1);
      r_cmd_valid <= w_dec;
      r_fw_marked <= w_gnt_fw && (fw_mark_i != '0);
      if (w_dec) begin
        r_cmd <= w_cmd;
        // runcmd wins never count against fw, so only a trig win ages it
        if (w_gnt_fw) begin
          r_starve <= '0;
        end else if (fw_tvalid && w_gnt_trig && !w_starved) begin
          r_starve <= r_starve + STARVE_W'(1);
        end
      end
    end
  end

  assign runcmd_tready = w_gnt_run;
  assign trig_tready   = w_gnt_trig;
  assign fw_tready     = w_gnt_fw;
  assign cmd_o         = r_cmd;
  assign cmd_valid_o   = r_cmd_valid;
  assign fw_marked_o   = r_fw_marked;
  assign frame_o       = w_dec;

endmodule
